// File: rtl/mem_ahb_defs.sv
// Shared AHB definitions for the memory slaves: transfer/response codes,
// controller state encoding and the byte-enable helper.
package mem_ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } ahb_state_e;

  // Lane mask for a transfer of 2^size bytes starting at byte lane offs
  // (up to 8 lanes; callers truncate to their own bus width).
  function automatic logic [7:0] gen_be(input logic [2:0] size, input logic [2:0] offs);
    logic [8:0] mask;
    mask = (9'd1 << (4'd1 << size)) - 9'd1;
    return mask[7:0] << offs;
  endfunction

endpackage

// File: rtl/sram_be_sp.sv
// Single-port synchronous RAM with per-byte write enables; the read
// register only updates when a read is requested.
module sram_be_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  ce_rd,
  input  logic [DATA_W/8-1:0]   we_be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and dout carry no reset; resetting a RAM forces it into
  // flops, and the controller never reads dout outside a read data phase.
  always_ff @(posedge clk) begin
    if (ce_rd)
      dout <= mem[addr];
    for (int i = 0; i < DATA_W/8; i++)
      if (we_be[i])
        mem[addr][8*i +: 8] <= din[8*i +: 8];
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB memory slave: configurable width/depth/read wait states, one-entry
// posted write buffer with byte-merge forwarding, two-cycle ERROR response.
module ahb_sram_ctrl
  import mem_ahb_defs::*;
#(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 17,
  parameter int RD_WAIT    = 0
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst,
  input  logic              hsel_s1,
  input  logic [1:0]        htrans_s1,
  input  logic [31:0]       haddr_s1,
  input  logic              hwrite_s1,
  input  logic [2:0]        hsize_s1,
  input  logic [2:0]        hburst_s1,
  input  logic [3:0]        hprot_s1,
  input  logic [DATA_W-1:0] hwdata_s1,
  output logic [DATA_W-1:0] hrdata_s1,
  output logic              hready_s1,
  output logic [1:0]        hresp_s1
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int WA_W  = MEM_ADDR_W - BSH;

  ahb_state_e state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;

  logic             acc, err, rd_issue, direct_wr, buf_wr, drain;
  logic [7:0]       align_mask;
  logic [WA_W-1:0]  haddr_word;
  logic [BYTES-1:0] be;

  logic             dp_rd_q, dp_wr_q;
  logic [WA_W-1:0]  dp_addr_q;
  logic [BYTES-1:0] dp_be_q;

  logic              wbuf_vld;
  logic [WA_W-1:0]   wbuf_addr;
  logic [BYTES-1:0]  wbuf_be;
  logic [DATA_W-1:0] wbuf_data;

  logic [BYTES-1:0]  fwd_be_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic              ram_ce;
  logic [BYTES-1:0]  ram_we;
  logic [WA_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic unused_ok;
  assign unused_ok = ^{hburst_s1, hprot_s1};

  // Address-phase decode
  always_comb begin
    align_mask = (8'd1 << hsize_s1) - 8'd1;
    err        = (|haddr_s1[31:MEM_ADDR_W]) || (hsize_s1 > 3'(BSH))
                 || (|(haddr_s1[7:0] & align_mask));
    haddr_word = haddr_s1[MEM_ADDR_W-1:BSH];
    be         = BYTES'(gen_be(hsize_s1, 3'(haddr_s1[BSH-1:0])));
    acc        = hsel_s1 && hready_s1 && htrans_s1[1];
    rd_issue   = acc && !err && !hwrite_s1;
    direct_wr  = dp_wr_q && !rd_issue;
    buf_wr     = dp_wr_q && rd_issue;
    drain      = wbuf_vld && !rd_issue && !dp_wr_q;
  end

  always_comb begin
    hready_s1 = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    hresp_s1  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  // NOTE: every default is assigned before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (acc && err) begin
          state_d = ST_ERR1;
        end else if (rd_issue && (RD_WAIT > 0)) begin
          state_d = ST_RWAIT;
          wcnt_d  = 2'(RD_WAIT);
        end
      end
      ST_RWAIT: begin
        if (wcnt_q == 2'd1) state_d = ST_IDLE;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Data-phase registers hold through wait states
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      dp_rd_q   <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      dp_be_q   <= '0;
    end else if (hready_s1) begin
      dp_rd_q   <= rd_issue;
      dp_wr_q   <= acc && !err && hwrite_s1;
      dp_addr_q <= haddr_word;
      dp_be_q   <= be;
    end
  end

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      wbuf_vld  <= 1'b0;
      wbuf_addr <= '0;
      wbuf_be   <= '0;
      wbuf_data <= '0;
    end else if (buf_wr) begin
      wbuf_vld  <= 1'b1;
      wbuf_addr <= dp_addr_q;
      wbuf_be   <= dp_be_q;
      wbuf_data <= hwdata_s1;
    end else if (drain) begin
      wbuf_vld  <= 1'b0;
    end
  end

  // Capture newer-than-RAM bytes at read issue; the concurrent write wins
  // because it is younger than anything sitting in the buffer.
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else if (rd_issue) begin
      if (dp_wr_q && dp_addr_q == haddr_word) begin
        fwd_be_q   <= dp_be_q;
        fwd_data_q <= hwdata_s1;
      end else if (wbuf_vld && wbuf_addr == haddr_word) begin
        fwd_be_q   <= wbuf_be;
        fwd_data_q <= wbuf_data;
      end else begin
        fwd_be_q   <= '0;
      end
    end
  end

  always_comb begin
    ram_ce   = rd_issue;
    ram_we   = '0;
    ram_addr = haddr_word;
    ram_din  = hwdata_s1;
    if (!rd_issue) begin
      if (direct_wr) begin
        ram_we   = dp_be_q;
        ram_addr = dp_addr_q;
      end else if (drain) begin
        ram_we   = wbuf_be;
        ram_addr = wbuf_addr;
        ram_din  = wbuf_data;
      end
    end
  end

  sram_be_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (WA_W)
  ) u_ram (
    .clk   (pll_core_cpuclk),
    .ce_rd (ram_ce),
    .we_be (ram_we),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  always_comb begin
    hrdata_s1 = '0;
    if (dp_rd_q)
      for (int i = 0; i < BYTES; i++)
        hrdata_s1[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : ram_dout[8*i +: 8];
  end

  // The write's own address-phase cycle issued no read, so the buffer drained.
  assert property (@(posedge pll_core_cpuclk) disable iff (pad_cpu_rst)
                   buf_wr |-> !wbuf_vld);

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: a 32-bit zero-wait instance and a 64-bit
// two-wait instance, checked cycle by cycle against a transfer-level model.
module tb_ahb_sram_ctrl;

  typedef enum int {K_NONE, K_RD, K_WR, K_ERR1, K_ERR2} kind_e;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase;
  logic        hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;

  logic [31:0] hrdata_a;
  logic        hready_a;
  logic [1:0]  hresp_a;
  logic [63:0] hrdata_b;
  logic        hready_b;
  logic [1:0]  hresp_b;

  logic        hready_o;
  logic [1:0]  hresp_o;
  logic [63:0] hrdata_o;

  int n_vec = 0;
  int n_bad = 0;
  int lo_cnt = 0;
  logic [63:0] last_rd = '0;
  logic [63:0] pend_wd = '0;

  logic [7:0] mm [int unsigned];
  kind_e       m_kind = K_NONE;
  int unsigned m_addr;
  int          m_size;
  int          m_wait;

  always #5 clk = ~clk;

  assign hready_o = phase ? hready_b : hready_a;
  assign hresp_o  = phase ? hresp_b  : hresp_a;
  assign hrdata_o = phase ? hrdata_b : {32'h0, hrdata_a};

  ahb_sram_ctrl #(.DATA_W(32), .MEM_ADDR_W(17), .RD_WAIT(0)) dut_a (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .hsel_s1         (hsel & ~phase),
    .htrans_s1       (htrans),
    .haddr_s1        (haddr),
    .hwrite_s1       (hwrite),
    .hsize_s1        (hsize),
    .hburst_s1       (3'b000),
    .hprot_s1        (4'b0011),
    .hwdata_s1       (hwdata[31:0]),
    .hrdata_s1       (hrdata_a),
    .hready_s1       (hready_a),
    .hresp_s1        (hresp_a)
  );

  ahb_sram_ctrl #(.DATA_W(64), .MEM_ADDR_W(17), .RD_WAIT(2)) dut_b (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .hsel_s1         (hsel & phase),
    .htrans_s1       (htrans),
    .haddr_s1        (haddr),
    .hwrite_s1       (hwrite),
    .hsize_s1        (hsize),
    .hburst_s1       (3'b000),
    .hprot_s1        (4'b0011),
    .hwdata_s1       (hwdata),
    .hrdata_s1       (hrdata_b),
    .hready_s1       (hready_b),
    .hresp_s1        (hresp_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one data phase in flight, memory as a byte map.
  always @(negedge clk) begin
    int nb, rw, ok_size;
    logic exp_rdy;
    logic [1:0] exp_resp;
    logic [63:0] exp_d, mask;
    int unsigned base, a;
    logic a_err;
    nb = phase ? 8 : 4;
    rw = phase ? 2 : 0;
    ok_size = phase ? 3 : 2;
    if (!hready_o) lo_cnt++;
    if (rst) begin
      m_kind = K_NONE;
    end else begin
      exp_rdy  = 1'b1;
      exp_resp = 2'b00;
      if (m_kind == K_RD && m_wait > 0) exp_rdy = 1'b0;
      if (m_kind == K_ERR1) begin exp_rdy = 1'b0; exp_resp = 2'b01; end
      if (m_kind == K_ERR2) exp_resp = 2'b01;
      check("hready", {63'h0, hready_o}, {63'h0, exp_rdy});
      check("hresp", {62'h0, hresp_o}, {62'h0, exp_resp});
      if (m_kind == K_RD) begin
        if (m_wait == 0) begin
          exp_d = '0;
          mask  = '0;
          base  = m_addr & ~(nb - 1);
          for (int i = 0; i < nb; i++)
            if (mm.exists(base + i)) begin
              exp_d[8*i +: 8] = mm[base + i];
              mask[8*i +: 8]  = 8'hFF;
            end
          if (mask != '0) check("hrdata", hrdata_o & mask, exp_d);
          last_rd = hrdata_o;
        end else begin
          m_wait--;
        end
      end else begin
        check("hrdata_idle", hrdata_o, 64'h0);
      end
      if (m_kind == K_WR)
        for (int i = 0; i < (1 << m_size); i++) begin
          a = m_addr + i;
          mm[a] = hwdata[8*(a % nb) +: 8];
        end
      if (m_kind == K_ERR1) begin
        m_kind = K_ERR2;
      end else if (exp_rdy) begin
        m_kind = K_NONE;
        if (hsel && htrans[1]) begin
          a_err = (haddr >= 32'h0002_0000) || (int'(hsize) > ok_size)
                  || ((haddr % (32'd1 << hsize)) != 0);
          m_addr = haddr;
          m_size = int'(hsize);
          m_wait = rw;
          if (a_err)       m_kind = K_ERR1;
          else if (hwrite) m_kind = K_WR;
          else             m_kind = K_RD;
        end
      end
    end
  end

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd);
    int n;
    logic rdy;
    hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = pend_wd;
    n = 0;
    do begin
      @(negedge clk);
      rdy = hready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: hready still 0 after %0d cycles, expected 1", n);
    end
    pend_wd = (sel && tr[1] && wr) ? wd : 64'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
    drive(1'b1, 2'b10, 1'b1, a, sz, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz);
    drive(1'b1, 2'b10, 1'b0, a, sz, 64'h0);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = '0; hwdata = '0;
    pend_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready", {63'h0, hready_o}, 64'h1);
    check("rst_hresp", {62'h0, hresp_o}, 64'h0);
    check("rst_hrdata", hrdata_o, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    phase = 1'b0;
    do_reset();
    check("rst_wbuf_vld", {63'h0, dut_a.wbuf_vld}, 64'h0);

    // Plain write then read
    wr(32'h100, 3'd2, 64'hDEADBEEF); idle();
    rd(32'h100, 3'd2); idle();
    check("rd_100", last_rd, 64'hDEADBEEF);

    // Read straight after write: buffered, forwarded, no stall
    lo_cnt = 0;
    wr(32'h200, 3'd2, 64'h11223344);
    rd(32'h200, 3'd2);
    check("wbuf_loaded", {63'h0, dut_a.wbuf_vld}, 64'h1);
    idle(); idle();
    check("raw_fwd", last_rd, 64'h11223344);
    check("raw_no_stall", 64'(lo_cnt), 64'h0);
    check("wbuf_drained", {63'h0, dut_a.wbuf_vld}, 64'h0);
    check("ram_200", {32'h0, dut_a.u_ram.mem['h80]}, 64'h11223344);

    // Partial merge from a concurrent byte write
    wr(32'h300, 3'd2, 64'hAABBCCDD); idle();
    wr(32'h301, 3'd0, 64'h0000EE00);
    rd(32'h300, 3'd2); idle();
    check("byte_merge", last_rd, 64'hAABBEEDD);

    // Forward from the buffer on a later read
    wr(32'h600, 3'd2, 64'h0BADCAFE);
    rd(32'h604, 3'd2);
    rd(32'h600, 3'd2); idle();
    check("wbuf_fwd", last_rd, 64'h0BADCAFE);

    // Top of the decoded range
    wr(32'h1FFFC, 3'd2, 64'hCAFEF00D); idle();
    rd(32'h1FFFC, 3'd2); idle();
    check("rd_top", last_rd, 64'hCAFEF00D);

    // Error responses; the errored write must not alias onto word 0
    wr(32'h0, 3'd2, 64'h12345678);
    wr(32'h20000, 3'd2, 64'hFFFFFFFF);
    idle();
    lo_cnt = 0;
    rd(32'h20000, 3'd2);
    rd(32'h401, 3'd1);
    check("err_one_stall", 64'(lo_cnt), 64'h1);
    rd(32'h400, 3'd3);
    rd(32'h0, 3'd2); idle();
    check("err_no_touch", last_rd, 64'h12345678);

    // Reset while a write sits in the buffer
    wr(32'h500, 3'd2, 64'h01020304); idle();
    wr(32'h500, 3'd2, 64'h55667788);
    rd(32'h504, 3'd2);
    hsel = 1'b0; htrans = 2'b00; hwdata = '0; pend_wd = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_hready", {63'h0, hready_o}, 64'h1);
    check("mid_rst_hresp", {62'h0, hresp_o}, 64'h0);
    check("mid_rst_hrdata", hrdata_o, 64'h0);
    check("mid_rst_wbuf", {63'h0, dut_a.wbuf_vld}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // The buffered write is discarded by reset
    mm[32'h500] = 8'h04; mm[32'h501] = 8'h03; mm[32'h502] = 8'h02; mm[32'h503] = 8'h01;
    check("ram_500_kept", {32'h0, dut_a.u_ram.mem['h140]}, 64'h01020304);
    rd(32'h500, 3'd2); idle();
    check("rd_500_after_rst", last_rd, 64'h01020304);

    // 64-bit instance with two read wait states
    phase = 1'b1;
    mm.delete();
    do_reset();
    wr(32'h100, 3'd3, 64'h0F0E0D0C_DEADBEEF); idle();
    lo_cnt = 0;
    rd(32'h100, 3'd2); idle();
    check("w2_stall", 64'(lo_cnt), 64'h2);
    check("w2_rd_100", last_rd, 64'h0F0E0D0C_DEADBEEF);
    wr(32'h108, 3'd3, 64'h01234567_89ABCDEF);
    rd(32'h108, 3'd3); idle();
    check("w2_dw_fwd", last_rd, 64'h01234567_89ABCDEF);
    wr(32'h10C, 3'd2, 64'hA5A5A5A5_00000000); idle();
    rd(32'h108, 3'd3); idle();
    check("w2_upper_word", last_rd, 64'hA5A5A5A5_89ABCDEF);
    rd(32'h104, 3'd3); idle();
    wr(32'h1FFF8, 3'd3, 64'h8877665544332211);
    rd(32'h1FFF8, 3'd3); idle();
    check("w2_top", last_rd, 64'h8877665544332211);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
